// File: rtl/step_key_front_end.sv
// rtl/step_key_front_end.sv - pushbutton synchronizer, one-shot FSM, step lockout filter and hex decoder
// Combinational 4-bit to 7-segment decoder for the DE2 HEX displays; segments active-low.
module hex7seg (
  input  logic [3:0] v,
  output logic [0:6] hex
);
  always_comb begin
    hex = 7'b1111111;
    case (v)
      4'h0: hex = 7'b0000001;
      4'h1: hex = 7'b1001111;
      4'h2: hex = 7'b0010010;
      4'h3: hex = 7'b0000110;
      4'h4: hex = 7'b1001100;
      4'h5: hex = 7'b0100100;
      4'h6: hex = 7'b0100000;
      4'h7: hex = 7'b0001111;
      4'h8: hex = 7'b0000000;
      4'h9: hex = 7'b0000100;
      4'hA: hex = 7'b0001000;
      4'hB: hex = 7'b1100000;
      4'hC: hex = 7'b0110001;
      4'hD: hex = 7'b1000010;
      4'hE: hex = 7'b0110000;
      4'hF: hex = 7'b0111000;
      default: hex = 7'b1111111;
    endcase
  end
endmodule

module step_key_front_end #(
  parameter int LOCKOUT_CYCLES = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       ResetN,
  input  logic       KeyN,
  output logic       Bo,
  output logic       StepOut,
  input  logic [3:0] V,
  output logic [0:6] Hex
);
  localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] BTN_IDLE  = 2'd0;
  localparam logic [1:0] BTN_PULSE = 2'd1;
  localparam logic [1:0] BTN_WAIT  = 2'd2;

  localparam logic [0:0] FLT_READY = 1'b0;
  localparam logic [0:0] FLT_LOCK  = 1'b1;

  logic          s1, s2;
  logic          pressed;
  logic [1:0]    btn_state, btn_next;
  logic [0:0]    flt_state;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; resets to the released level so no press is seen out of reset.
  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= KeyN;
      s2 <= s1;
    end
  end

  assign pressed = ~s2;

  always_comb begin
    btn_next = BTN_IDLE;
    case (btn_state)
      BTN_IDLE:  btn_next = pressed ? BTN_PULSE : BTN_IDLE;
      BTN_PULSE: btn_next = pressed ? BTN_WAIT  : BTN_IDLE;
      BTN_WAIT:  btn_next = pressed ? BTN_WAIT  : BTN_IDLE;
      default:   btn_next = BTN_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      btn_state <= BTN_IDLE;
    end else begin
      btn_state <= btn_next;
    end
  end

  // Moore output decoded from state so an asynchronous reset clears it immediately.
  assign Bo = (btn_state == BTN_PULSE);

  // Lockout: a Bo arriving in the same cycle the counter expires is dropped, giving L+1 spacing.
  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      flt_state <= FLT_READY;
      cnt       <= '0;
      StepOut   <= 1'b0;
    end else begin
      StepOut <= 1'b0;
      case (flt_state)
        FLT_READY: begin
          if (Bo) begin
            StepOut   <= 1'b1;
            cnt       <= CNT_LOAD;
            flt_state <= FLT_LOCK;
          end
        end
        FLT_LOCK: begin
          if (cnt == '0) begin
            flt_state <= FLT_READY;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: flt_state <= FLT_READY;
      endcase
    end
  end

  hex7seg u_hex (
    .v   (V),
    .hex (Hex)
  );
endmodule

// File: tb/tb_step_key_front_end.sv
// tb/tb_step_key_front_end.sv - directed checks of key synchronizer, lockout filter and hex decoder
module tb_step_key_front_end;
  localparam int LOCK = 8;

  typedef struct {
    logic [3:0] v;
    logic [0:6] hex;
  } hex_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] v = 4'h0;
  logic       bo, step;
  logic [0:6] hex;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bo_cnt = 0;
  int step_cnt = 0;
  int step_q[$];

  hex_vec_t tbl[16];

  step_key_front_end #(.LOCKOUT_CYCLES(LOCK)) dut (
    .CLOCK_50 (clk),
    .ResetN   (rst_n),
    .KeyN     (key_n),
    .Bo       (bo),
    .StepOut  (step),
    .V        (v),
    .Hex      (hex)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bo) bo_cnt++;
    if (step) begin
      step_cnt++;
      step_q.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    bo_cnt = 0;
    step_cnt = 0;
    step_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press: KeyN low across exactly one rising edge.
  task automatic press1();
    key_n = 1'b0;
    @(negedge clk);
    key_n = 1'b1;
  endtask

  task automatic gap_test(input string name, input int gap, input int exp_steps);
    clear_counts();
    press1();
    idle(gap - 1);
    press1();
    idle(15);
    check({name, "_bo_count"}, bo_cnt, 2);
    check({name, "_step_count"}, step_cnt, exp_steps);
    if (exp_steps == 2) begin
      if (step_q.size() == 2) begin
        check({name, "_step_spacing"}, step_q[1] - step_q[0], gap);
        check({name, "_spacing_min"}, int'(step_q[1] - step_q[0] >= LOCK + 1), 1);
      end else begin
        check({name, "_step_queue"}, step_q.size(), 2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_bo[5];
    int exp_step[5];
    int n;

    tbl[0]  = '{4'h0, 7'b0000001}; tbl[1]  = '{4'h1, 7'b1001111};
    tbl[2]  = '{4'h2, 7'b0010010}; tbl[3]  = '{4'h3, 7'b0000110};
    tbl[4]  = '{4'h4, 7'b1001100}; tbl[5]  = '{4'h5, 7'b0100100};
    tbl[6]  = '{4'h6, 7'b0100000}; tbl[7]  = '{4'h7, 7'b0001111};
    tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0000100};
    tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b1100000};
    tbl[12] = '{4'hC, 7'b0110001}; tbl[13] = '{4'hD, 7'b1000010};
    tbl[14] = '{4'hE, 7'b0110000}; tbl[15] = '{4'hF, 7'b0111000};
    exp_bo   = '{0, 0, 1, 0, 0};
    exp_step = '{0, 0, 0, 1, 0};

    // Reset held while the key chatters.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      key_n = ~key_n;
      #1;
      check("reset_bo", bo, 0);
      check("reset_step", step, 0);
    end
    @(negedge clk);
    key_n = 1'b1;
    rst_n = 1'b1;
    clear_counts();
    idle(10);
    check("post_reset_bo_count", bo_cnt, 0);
    check("post_reset_step_count", step_cnt, 0);

    // Single-cycle press latency: Bo at 3rd edge, StepOut at 4th.
    key_n = 1'b0;
    @(negedge clk);
    key_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("short_bo_n%0d", k + 1), bo, exp_bo[k]);
      check($sformatf("short_step_n%0d", k + 1), step, exp_step[k]);
    end
    idle(12);

    // Held key gives one pulse; re-press gives another.
    clear_counts();
    key_n = 1'b0;
    idle(50);
    key_n = 1'b1;
    idle(15);
    check("held_bo_count", bo_cnt, 1);
    check("held_step_count", step_cnt, 1);
    clear_counts();
    press1();
    idle(15);
    check("repress_bo_count", bo_cnt, 1);
    check("repress_step_count", step_cnt, 1);

    // Lockout boundaries: gap 8 collides with counter expiry, gap 9 is the first accepted.
    gap_test("gap4", 4, 1);
    gap_test("gap8", 8, 1);
    gap_test("gap9", 9, 2);
    gap_test("gap12", 12, 2);

    // Asynchronous reset while Bo is high.
    press1();
    n = 0;
    while (!bo && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("async_bo_seen", bo, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_bo_cut", bo, 0);
    check("async_bo_step", step, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    idle(5);
    check("async_no_spurious", bo_cnt + step_cnt, 0);

    // FSM restarts from IDLE: full latency again, then cut StepOut.
    key_n = 1'b0;
    @(negedge clk);
    key_n = 1'b1;
    check("restart_bo_n1", bo, 0);
    @(negedge clk);
    check("restart_bo_n2", bo, 0);
    @(negedge clk);
    check("restart_bo_n3", bo, 1);
    @(negedge clk);
    check("restart_step_n4", step, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_step_cut", step, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Decoder sweep.
    for (int i = 0; i < 16; i++) begin
      v = tbl[i].v;
      #1;
      check($sformatf("hex_%0h", tbl[i].v), int'(hex), int'(tbl[i].hex));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
